// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between instruction fetch and data access.
// Handles one transaction at a time, arbitrates round-robin and kills hung responses with a watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [3:0]        dc_req_we,
  input  logic [DATA_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_we,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic              mem_req_tag,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              stall,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] hold_addr;
  logic [3:0]        hold_we;
  logic [DATA_W-1:0] hold_wdata;
  logic              hold_tag;
  logic              grant_ic;
  logic              grant_dc;
  logic              resp_hit;
  logic              timeout_hit;
  logic [DATA_W-1:0] resp_value;

  // Grants are gated by reset_n so nothing is accepted while reset is held.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == IDLE && reset_n) begin
      if (ic_req_valid && dc_req_valid) begin
        grant_ic = last_grant;
        grant_dc = !last_grant;
      end else if (ic_req_valid) begin
        grant_ic = 1'b1;
      end else if (dc_req_valid) begin
        grant_dc = 1'b1;
      end
    end
  end

  assign ic_req_ready  = grant_ic;
  assign dc_req_ready  = grant_dc;
  assign resp_hit      = (state == WAIT) && mem_resp_valid;
  assign timeout_hit   = (state == WAIT) && !mem_resp_valid && (wait_cnt == LAST_CNT);
  assign resp_value    = (resp_hit && hold_we == 4'd0) ? mem_resp_data : '0;
  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = hold_addr;
  assign mem_req_we    = hold_we;
  assign mem_req_wdata = hold_wdata;
  assign mem_req_tag   = hold_tag;
  assign stall         = (state != IDLE) || ic_req_valid || dc_req_valid;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_ic || grant_dc) state_next = ISSUE;
      ISSUE:   if (mem_req_ready) state_next = WAIT;
      WAIT:    if (resp_hit || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant    <= 1'b0;
      wait_cnt      <= '0;
      hold_addr     <= '0;
      hold_we       <= '0;
      hold_wdata    <= '0;
      hold_tag      <= 1'b0;
      timeout_err   <= 1'b0;
      ic_resp_valid <= 1'b0;
      ic_resp_data  <= '0;
      dc_resp_valid <= 1'b0;
      dc_resp_data  <= '0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      if (grant_dc) begin
        hold_addr  <= dc_req_addr & WORD_MASK;
        hold_we    <= dc_req_we;
        hold_wdata <= dc_req_wdata;
        hold_tag   <= 1'b1;
        last_grant <= 1'b1;
      end else if (grant_ic) begin
        hold_addr  <= ic_req_addr & WORD_MASK;
        hold_we    <= 4'd0;
        hold_wdata <= '0;
        hold_tag   <= 1'b0;
        last_grant <= 1'b0;
      end
      if (state == ISSUE && mem_req_ready) wait_cnt <= '0;
      else if (state == WAIT)              wait_cnt <= wait_cnt + CNT_W'(1);
      if (timeout_hit) timeout_err <= 1'b1;
      // A timeout completes exactly like a response, just with zero data.
      if (resp_hit || timeout_hit) begin
        if (hold_tag) begin
          dc_resp_valid <= 1'b1;
          dc_resp_data  <= resp_value;
        end else begin
          ic_resp_valid <= 1'b1;
          ic_resp_data  <= resp_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses are queued at accept time
// and matched (tag, data, cycle) by a monitor when a resp pulse appears.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ic_req_valid = 1'b0;
  logic [31:0] ic_req_addr = '0;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        dc_req_valid = 1'b0;
  logic [31:0] dc_req_addr = '0;
  logic [3:0]  dc_req_we = '0;
  logic [31:0] dc_req_wdata = '0;
  logic        dc_req_ready;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_req_tag;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        stall;
  logic        timeout_err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_tag(mem_req_tag),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          tag;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ic_resp_valid || dc_resp_valid) begin
      checkOutput("resp_exclusive", 64'(ic_resp_valid & dc_resp_valid), 64'd0);
      if (sb.size() == 0) begin
        checkOutput("resp_unexpected", 64'(ic_resp_valid | dc_resp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("resp_tag", 64'(dc_resp_valid), 64'(mon_e.tag));
        checkOutput("resp_data", 64'(dc_resp_valid ? dc_resp_data : ic_resp_data), 64'(mon_e.data));
        checkOutput("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic waitAccept(input bit is_dc, output int acc);
    int n = 0;
    @(negedge clk);
    while (!(is_dc ? dc_req_ready : ic_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(is_dc ? "dc_req_ready" : "ic_req_ready",
                64'(is_dc ? dc_req_ready : ic_req_ready), 64'd1);
    checkOutput(is_dc ? "ic_req_ready_other" : "dc_req_ready_other",
                64'(is_dc ? ic_req_ready : dc_req_ready), 64'd0);
    acc = cyc;
  endtask

  task automatic serviceMem(input logic [31:0] ea, input logic [3:0] ewe, input logic [31:0] ewd,
                            input bit etag, input int rd, input int dly, input bit respond,
                            input logic [31:0] rdata);
    for (int i = 0; i <= rd; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      mem_req_ready = (i == rd);
      @(negedge clk);
      checkOutput("mem_req_valid", 64'(mem_req_valid), 64'd1);
      checkOutput("mem_req_addr", 64'(mem_req_addr), 64'(ea));
      checkOutput("mem_req_we", 64'(mem_req_we), 64'(ewe));
      checkOutput("mem_req_wdata", 64'(mem_req_wdata), 64'(ewd));
      checkOutput("mem_req_tag", 64'(mem_req_tag), 64'(etag));
      checkOutput("stall_issue", 64'(stall), 64'd1);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    if (respond) begin
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = rdata;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
    end
  endtask

  task automatic waitResp();
    int n = 0;
    while (sb.size() != 0 && n < TO + 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resp_arrived", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic applyStimulus(input bit is_dc, input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wdata, input int rd, input int dly,
                               input bit respond, input logic [31:0] rdata);
    int acc;
    logic [31:0] ed;
    @(posedge clk); #1;
    if (is_dc) begin
      dc_req_valid = 1'b1;
      dc_req_addr  = addr;
      dc_req_we    = we;
      dc_req_wdata = wdata;
    end else begin
      ic_req_valid = 1'b1;
      ic_req_addr  = addr;
    end
    waitAccept(is_dc, acc);
    ed = (!respond || (is_dc && we != 4'd0)) ? 32'd0 : rdata;
    sb.push_back('{is_dc, ed, respond ? acc + 3 + rd + dly : acc + 2 + rd + TO});
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    serviceMem(addr & 32'hFFFF_FFFC, is_dc ? we : 4'd0, is_dc ? wdata : 32'd0, is_dc,
               rd, dly, respond, rdata);
    waitResp();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int acc;
    bit is_dc;
    logic [3:0] we;

    // Reset held with both requesters asking: nothing may be accepted.
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_3008;
    dc_req_addr  = 32'h0000_2004;
    repeat (2) @(negedge clk);
    checkOutput("reset_ic_ready", 64'(ic_req_ready), 64'd0);
    checkOutput("reset_dc_ready", 64'(dc_req_ready), 64'd0);
    checkOutput("reset_mem_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("reset_timeout_err", 64'(timeout_err), 64'd0);
    checkOutput("reset_ic_resp", 64'(ic_resp_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // First conflict after reset goes to dc, the next conflict to ic.
    waitAccept(1'b1, acc);
    sb.push_back('{1'b1, 32'h0BAD_F00D, acc + 3});
    @(posedge clk); #1;
    dc_req_valid = 1'b0;
    serviceMem(32'h0000_2004, 4'd0, 32'd0, 1'b1, 0, 0, 1'b1, 32'h0BAD_F00D);
    dc_req_valid = 1'b1;
    waitAccept(1'b0, acc);
    sb.push_back('{1'b0, 32'h1111_2222, acc + 3});
    @(posedge clk); #1;
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    serviceMem(32'h0000_3008, 4'd0, 32'd0, 1'b0, 0, 0, 1'b1, 32'h1111_2222);
    waitResp();

    // Fetch of an unaligned address; dc outputs must be left alone.
    checkOutput("dc_data_before", 64'(dc_resp_data), 64'h0BAD_F00D);
    applyStimulus(1'b0, 32'h0000_1003, 4'd0, 32'd0, 0, 0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("dc_data_untouched", 64'(dc_resp_data), 64'h0BAD_F00D);
    checkOutput("ic_data_held", 64'(ic_resp_data), 64'hDEAD_BEEF);

    // Store with a slow memory: ack carries zero data.
    applyStimulus(1'b1, 32'h0000_4000, 4'b0011, 32'h1234_5678, 4, 1, 1'b1, 32'hFFFF_FFFF);
    checkOutput("store_ack_data", 64'(dc_resp_data), 64'd0);
    checkOutput("ic_data_untouched", 64'(ic_resp_data), 64'hDEAD_BEEF);
    checkOutput("timeout_err_clear", 64'(timeout_err), 64'd0);

    // Memory never answers: watchdog completes the fetch and latches the error.
    applyStimulus(1'b0, 32'h0000_5000, 4'd0, 32'd0, 0, 0, 1'b0, 32'd0);
    checkOutput("timeout_err_set", 64'(timeout_err), 64'd1);
    applyStimulus(1'b1, 32'h0000_6002, 4'd0, 32'd0, 1, 2, 1'b1, 32'hCAFE_F00D);
    checkOutput("timeout_err_sticky", 64'(timeout_err), 64'd1);

    // Mixed traffic, including responses landing on the last watchdog cycle.
    for (int k = 0; k < 6; k++) begin
      is_dc = 1'($urandom_range(0, 1));
      we = is_dc ? 4'($urandom_range(0, 15)) : 4'd0;
      applyStimulus(is_dc, $urandom, we, is_dc ? $urandom : 32'd0,
                    $urandom_range(0, 2), $urandom_range(0, TO - 1), 1'b1, $urandom);
    end

    // Reset during WAIT drops the transaction; a stray response afterwards is ignored.
    @(posedge clk); #1;
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_7000;
    waitAccept(1'b0, acc);
    @(posedge clk); #1;
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("abort_stall", 64'(stall), 64'd0);
    checkOutput("abort_timeout_err", 64'(timeout_err), 64'd0);
    @(posedge clk); #1;
    reset_n        = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (TO + 4) @(negedge clk);
    checkOutput("idle_stall", 64'(stall), 64'd0);
    checkOutput("idle_mem_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("stray_ic_data", 64'(ic_resp_data), 64'd0);
    applyStimulus(1'b1, 32'h0000_8000, 4'd0, 32'd0, 0, 0, 1'b1, 32'h0F0F_0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
